// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters,
// with registered ALU inputs and a registered, ID-tagged valid/ready response.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_id,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    logic cur_id, last_id, opp, sel1, grant;
    assign opp = !rst && (state == IDLE || (state == RESP && rsp_valid && rsp_ready));
    // requester 1 wins if it is alone, or on contention when requester 0 was granted last
    assign sel1 = req1_valid && (!req0_valid || !last_id);
    assign req0_ready = opp && req0_valid && !sel1;
    assign req1_ready = opp && sel1;
    assign grant = req0_ready || req1_ready;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_id    <= 1'b1;
            cur_id     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= 1'b0;
        end else begin
            if (grant) begin
                alu_a    <= sel1 ? req1_a : req0_a;
                alu_b    <= sel1 ? req1_b : req0_b;
                alu_ctrl <= sel1 ? req1_op : req0_op;
                cur_id   <= sel1;
                last_id  <= sel1;
            end
            case (state)
                IDLE: state <= grant ? EXEC : IDLE;
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_id     <= cur_id;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= grant ? EXEC : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
